// File: rtl/jtdd_mailbox_pkg.sv
// jtdd_mailbox shared helpers.
// Width rules for channel index and FIFO pointers.
package jtdd_mailbox_pkg;

    // Channel index is at least one bit, even for a single channel.
    function automatic int cw_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // DEPTH=1 keeps a 1-bit pointer that never moves.
    function automatic int pw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int nw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jtdd_mailbox_if.sv
// Writer/reader bus of the command mailbox.
// master = CPU side, slave = mailbox.
interface jtdd_mailbox_if #(
    parameter int DW = 8,
    parameter int CH = 2,
    parameter int CW = 1
) ();
    logic          wr_cen;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [DW-1:0] wr_data;
    logic          rd_cen;
    logic          rd_en;
    logic [CW-1:0] rd_ch;
    logic [DW-1:0] rd_data;
    logic [CH-1:0] irq_ack;
    logic [CH-1:0] ovf_clr;
    logic [CH-1:0] irq;
    logic [CH-1:0] empty;
    logic [CH-1:0] full;
    logic [CH-1:0] ovf;

    modport master (
        output wr_cen, wr_en, wr_ch, wr_data,
        output rd_cen, rd_en, rd_ch, irq_ack, ovf_clr,
        input  rd_data, irq, empty, full, ovf
    );

    modport slave (
        input  wr_cen, wr_en, wr_ch, wr_data,
        input  rd_cen, rd_en, rd_ch, irq_ack, ovf_clr,
        output rd_data, irq, empty, full, ovf
    );
endinterface

// File: rtl/jtdd_mailbox_fifo.sv
// One mailbox channel: register FIFO with count,
// sticky overflow and level or edge-style IRQ.
module jtdd_mailbox_fifo #(
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int PW     = 2,
    parameter int NW     = 3,
    parameter int OVWR   = 0,
    parameter int IRQLVL = 1
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          i_we,
    input  logic          i_re,
    input  logic          i_ack,
    input  logic          i_clr,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_head,
    output logic          o_pop,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_irq,
    output logic          o_ovf
);
    // Zero step pins the pointer at 0 when DEPTH=1.
    localparam logic [PW-1:0] STEP = (DEPTH > 1) ? PW'(1) : '0;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [NW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_irq;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_hit;
    logic          w_ovwr;
    logic [PW-1:0] w_wlast;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == NW'(DEPTH));
    assign w_pop   = i_re & ~w_empty;
    // A pop in the same cycle frees the slot for a write to a full channel.
    assign w_push  = i_we & (~w_full | w_pop);
    assign w_hit   = i_we & w_full & ~w_pop;
    assign w_ovwr  = w_hit & (OVWR != 0);
    assign w_wlast = r_wptr - STEP;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end else if (w_ovwr) begin
            r_mem[w_wlast] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + STEP;
            if (w_pop)  r_rptr <= r_rptr + STEP;
            if (w_push & ~w_pop)      r_cnt <= r_cnt + NW'(1);
            else if (w_pop & ~w_push) r_cnt <= r_cnt - NW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_hit)      r_ovf <= 1'b1;
            else if (i_clr) r_ovf <= 1'b0;
            if (w_push | w_ovwr) r_irq <= 1'b1;
            else if (i_ack)      r_irq <= 1'b0;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_pop   = w_pop;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_ovf   = r_ovf;
    assign o_irq   = (IRQLVL != 0) ? ~w_empty : r_irq;

endmodule

// File: rtl/jtdd_mailbox.sv
// Multi-channel command mailbox between the main CPU
// and the sound/MCU readers.
module jtdd_mailbox
    import jtdd_mailbox_pkg::*;
#(
    parameter int DW     = 8,
    parameter int CH     = 2,
    parameter int DEPTH  = 4,
    parameter int OVWR   = 0,
    parameter int IRQLVL = 1
) (
    input  logic           clk,
    input  logic           rstb,
    jtdd_mailbox_if.slave  bus
);
    localparam int CW = cw_of(CH);
    localparam int PW = pw_of(DEPTH);
    localparam int NW = nw_of(DEPTH);

    logic [CH-1:0] w_pop;
    logic [CH-1:0] w_empty;
    logic [CH-1:0] w_full;
    logic [CH-1:0] w_irq;
    logic [CH-1:0] w_ovf;
    logic [DW-1:0] w_head [CH];
    logic [DW-1:0] w_rd_head;
    logic [DW-1:0] r_rd_data;

    // Indices >= CH match no channel, so their strobes vanish here.
    for (genvar n = 0; n < CH; n++) begin : g_ch
        jtdd_mailbox_fifo #(
            .DW     (DW),
            .DEPTH  (DEPTH),
            .PW     (PW),
            .NW     (NW),
            .OVWR   (OVWR),
            .IRQLVL (IRQLVL)
        ) u_fifo (
            .clk     (clk),
            .rstb    (rstb),
            .i_we    (bus.wr_cen & bus.wr_en
                      & (bus.wr_ch == CW'(n))),
            .i_re    (bus.rd_cen & bus.rd_en
                      & (bus.rd_ch == CW'(n))),
            .i_ack   (bus.rd_cen & bus.irq_ack[n]),
            .i_clr   (bus.wr_cen & bus.ovf_clr[n]),
            .i_data  (bus.wr_data),
            .o_head  (w_head[n]),
            .o_pop   (w_pop[n]),
            .o_empty (w_empty[n]),
            .o_full  (w_full[n]),
            .o_irq   (w_irq[n]),
            .o_ovf   (w_ovf[n])
        );
    end

    always_comb begin
        w_rd_head = '0;
        for (int n = 0; n < CH; n++) begin
            if (w_pop[n]) w_rd_head = w_head[n];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)       r_rd_data <= '0;
        else if (|w_pop) r_rd_data <= w_rd_head;
    end

    assign bus.rd_data = r_rd_data;
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.irq     = w_irq;
    assign bus.ovf     = w_ovf;

endmodule

// File: tb/tb_jtdd_mailbox.sv
// Scoreboard bench for jtdd_mailbox: two configurations
// (drop/level IRQ and overwrite/acked IRQ) share one stimulus.
module tb_jtdd_mailbox;
    localparam int CH = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    jtdd_mailbox_if #(.DW(8), .CH(CH), .CW(2)) ifa ();
    jtdd_mailbox_if #(.DW(8), .CH(CH), .CW(2)) ifb ();

    jtdd_mailbox #(
        .DW(8), .CH(CH), .DEPTH(DEPTH), .OVWR(0), .IRQLVL(1)
    ) dut_a (.clk(clk), .rstb(rstb), .bus(ifa));

    jtdd_mailbox #(
        .DW(8), .CH(CH), .DEPTH(DEPTH), .OVWR(1), .IRQLVL(0)
    ) dut_b (.clk(clk), .rstb(rstb), .bus(ifb));

    typedef struct packed {
        logic [7:0] rd_a;
        logic [7:0] rd_b;
        logic [2:0] irq_a, irq_b;
        logic [2:0] emp_a, emp_b;
        logic [2:0] full_a, full_b;
        logic [2:0] ovf_a, ovf_b;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;

    // Reference model: per (config, channel) queue of entries.
    logic [7:0] mq [6][$];
    logic [7:0] mrd [2];
    bit         movf [6];
    bit         mirq [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            mq[k].delete();
            movf[k] = 0;
            mirq[k] = 0;
        end
        mrd[0] = 8'h00;
        mrd[1] = 8'h00;
    endtask

    task automatic model_step(input int cfg, input bit wcen, input bit wen,
                              input int wch, input logic [7:0] wd,
                              input bit rcen, input bit ren, input int rch,
                              input logic [2:0] ack, input logic [2:0] clr);
        for (int n = 0; n < CH; n++) begin
            int  k;
            int  sz;
            bit  we, pe, pop_ok, oset, iset;
            k = cfg * CH + n;
            sz = mq[k].size();
            we = wcen && wen && (wch == n);
            pe = rcen && ren && (rch == n);
            pop_ok = pe && (sz > 0);
            oset = 0;
            iset = 0;
            if (pop_ok) mrd[cfg] = mq[k].pop_front();
            if (we) begin
                if (sz < DEPTH || pop_ok) begin
                    mq[k].push_back(wd);
                    iset = 1;
                end else begin
                    oset = 1;
                    if (cfg == 1) begin
                        mq[k][mq[k].size() - 1] = wd;
                        iset = 1;
                    end
                end
            end
            if (oset) movf[k] = 1;
            else if (wcen && clr[n]) movf[k] = 0;
            if (iset) mirq[k] = 1;
            else if (rcen && ack[n]) mirq[k] = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.rd_a = mrd[0];
        e.rd_b = mrd[1];
        for (int n = 0; n < CH; n++) begin
            e.emp_a[n]  = (mq[n].size() == 0);
            e.emp_b[n]  = (mq[CH + n].size() == 0);
            e.full_a[n] = (mq[n].size() == DEPTH);
            e.full_b[n] = (mq[CH + n].size() == DEPTH);
            e.ovf_a[n]  = movf[n];
            e.ovf_b[n]  = movf[CH + n];
            e.irq_a[n]  = (mq[n].size() != 0);
            e.irq_b[n]  = mirq[CH + n];
        end
        return e;
    endfunction

    // Called at a negedge; returns at the next negedge.
    task automatic step(input bit wcen, input bit wen, input int wch,
                        input logic [7:0] wd, input bit rcen, input bit ren,
                        input int rch, input logic [2:0] ack,
                        input logic [2:0] clr);
        ifa.wr_cen = wcen;  ifb.wr_cen = wcen;
        ifa.wr_en = wen;    ifb.wr_en = wen;
        ifa.wr_ch = 2'(wch); ifb.wr_ch = 2'(wch);
        ifa.wr_data = wd;   ifb.wr_data = wd;
        ifa.rd_cen = rcen;  ifb.rd_cen = rcen;
        ifa.rd_en = ren;    ifb.rd_en = ren;
        ifa.rd_ch = 2'(rch); ifb.rd_ch = 2'(rch);
        ifa.irq_ack = ack;  ifb.irq_ack = ack;
        ifa.ovf_clr = clr;  ifb.ovf_clr = clr;
        model_step(0, wcen, wen, wch, wd, rcen, ren, rch, ack, clr);
        model_step(1, wcen, wen, wch, wd, rcen, ren, rch, ack, clr);
        expq.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input logic [7:0] d);
        step(1, 1, ch, d, 1, 0, 0, 3'b0, 3'b0);
    endtask

    task automatic pop(input int ch);
        step(1, 0, 0, 8'h00, 1, 1, ch, 3'b0, 3'b0);
    endtask

    task automatic idle();
        step(1, 0, 0, 8'h00, 1, 0, 0, 3'b0, 3'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_a"}, ifa.rd_data, 0);
        chk({tag, "_rd_b"}, ifb.rd_data, 0);
        chk({tag, "_empty_a"}, ifa.empty, 3'b111);
        chk({tag, "_empty_b"}, ifb.empty, 3'b111);
        chk({tag, "_full_a"}, ifa.full, 0);
        chk({tag, "_full_b"}, ifb.full, 0);
        chk({tag, "_irq_a"}, ifa.irq, 0);
        chk({tag, "_irq_b"}, ifb.irq, 0);
        chk({tag, "_ovf_a"}, ifa.ovf, 0);
        chk({tag, "_ovf_b"}, ifb.ovf, 0);
    endtask

    // Monitor: every cycle out of reset the DUTs present their outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstb && expq.size() > 0) begin
                e = expq.pop_front();
                chk("rd_data_a", ifa.rd_data, e.rd_a);
                chk("rd_data_b", ifb.rd_data, e.rd_b);
                chk("irq_a", ifa.irq, e.irq_a);
                chk("irq_b", ifb.irq, e.irq_b);
                chk("empty_a", ifa.empty, e.emp_a);
                chk("empty_b", ifb.empty, e.emp_b);
                chk("full_a", ifa.full, e.full_a);
                chk("full_b", ifb.full, e.full_b);
                chk("ovf_a", ifa.ovf, e.ovf_a);
                chk("ovf_b", ifb.ovf, e.ovf_b);
            end
        end
    end

    initial begin
        model_reset();
        ifa.wr_cen = 0; ifb.wr_cen = 0;
        ifa.wr_en = 0;  ifb.wr_en = 0;
        ifa.wr_ch = 0;  ifb.wr_ch = 0;
        ifa.wr_data = 0; ifb.wr_data = 0;
        ifa.rd_cen = 0; ifb.rd_cen = 0;
        ifa.rd_en = 0;  ifb.rd_en = 0;
        ifa.rd_ch = 0;  ifb.rd_ch = 0;
        ifa.irq_ack = 0; ifb.irq_ack = 0;
        ifa.ovf_clr = 0; ifb.ovf_clr = 0;
        repeat (2) @(negedge clk);
        chk_reset("init");
        rstb = 1'b1;
        @(negedge clk);

        // FIFO order on ch1.
        wr(1, 8'h11); wr(1, 8'h22); wr(1, 8'h33);
        pop(1); pop(1); pop(1);
        idle();

        // Overflow on ch0: drop vs overwrite, then clear.
        for (int i = 1; i <= 5; i++) wr(0, 8'(i));
        idle();
        for (int i = 0; i < 4; i++) pop(0);
        step(1, 0, 0, 8'h00, 0, 0, 0, 3'b0, 3'b001);
        idle();

        // Full channel with write and pop together.
        for (int i = 0; i < 4; i++) wr(0, 8'h40 + 8'(i));
        step(1, 1, 0, 8'h66, 1, 1, 0, 3'b0, 3'b0);
        for (int i = 0; i < 4; i++) pop(0);
        pop(0);

        // Empty channel: write and pop together stores, no bypass.
        step(1, 1, 2, 8'h5a, 1, 1, 2, 3'b0, 3'b0);
        pop(2);

        // Acked IRQ: set wins over a concurrent ack.
        wr(1, 8'h71);
        step(1, 1, 1, 8'h72, 1, 0, 0, 3'b010, 3'b0);
        step(1, 0, 0, 8'h00, 1, 0, 0, 3'b010, 3'b0);
        pop(1); pop(1);

        // Out-of-range channel, missing enables, ovf clear vs set.
        wr(3, 8'hee);
        step(1, 0, 0, 8'h00, 1, 1, 3, 3'b0, 3'b0);
        step(0, 1, 2, 8'hbb, 0, 1, 2, 3'b0, 3'b0);
        for (int i = 0; i < 4; i++) wr(2, 8'h90 + 8'(i));
        step(1, 1, 2, 8'h99, 1, 0, 0, 3'b0, 3'b100);
        step(1, 0, 0, 8'h00, 1, 0, 0, 3'b0, 3'b100);
        for (int i = 0; i < 4; i++) pop(2);

        // Asynchronous reset with traffic in flight.
        wr(0, 8'hc1); wr(0, 8'hc2); wr(0, 8'hc3);
        pop(0);
        ifa.wr_en = 0; ifb.wr_en = 0;
        ifa.rd_en = 0; ifb.rd_en = 0;
        #2 rstb = 1'b0;
        #1 chk_reset("midrst");
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3), 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0,
                 ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b0);
        end

        idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
